// File: rtl/axis_filter_pkg.sv
// Shared types and the header compare used by the header filter.
package axis_filter_pkg;

  // Widest header the compare function accepts; narrower headers are zero-extended.
  localparam int HDR_MAX_BITS = 256;

  // Packet-level filter state.
  typedef enum logic [1:0] {
    FIRST = 2'd0,
    PASS  = 2'd1,
    DROP  = 2'd2
  } state_t;

  // A header hits when every masked bit equals the match value; invert flips the sense.
  function automatic logic header_match(
    input logic [HDR_MAX_BITS-1:0] header,
    input logic [HDR_MAX_BITS-1:0] match,
    input logic [HDR_MAX_BITS-1:0] mask,
    input logic                    invert
  );
    return (((header ^ match) & mask) == '0) ^ invert;
  endfunction

endpackage

// File: rtl/axis_filter_stats.sv
// Two saturating packet counters driven by single-cycle strobes.
module axis_filter_stats #(
  parameter int STAT_CTR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      inc_pass,
  input  logic                      inc_drop,
  output logic [STAT_CTR_WIDTH-1:0] stat_passed,
  output logic [STAT_CTR_WIDTH-1:0] stat_dropped
);

  // Count forwarded and dropped packets, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      stat_passed  <= '0;
      stat_dropped <= '0;
    end else begin
      if (inc_pass && (stat_passed != '1)) begin
        stat_passed <= stat_passed + 1'b1;
      end
      if (inc_drop && (stat_dropped != '1)) begin
        stat_dropped <= stat_dropped + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_header_filter.sv
// Header-based packet filter: decides pass/drop on the first beat of each packet,
// forwards passed beats through one register slice, and counts packets.
//
// Handshake: a beat moves across an interface on a clock edge where tvalid && tready
// are both high; a source holds its beat stable while tvalid && !tready, and tready
// never depends on the same interface's tvalid.
module axis_header_filter
  import axis_filter_pkg::*;
#(
  parameter int AXIS_BYTES          = 1,
  parameter int AXIS_USER_BITS      = 1,
  parameter int HEADER_LENGTH_BYTES = 1,
  parameter int STAT_CTR_WIDTH      = 32
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic [HEADER_LENGTH_BYTES*8-1:0] cfg_match,
  input  logic [HEADER_LENGTH_BYTES*8-1:0] cfg_mask,
  input  logic                             cfg_invert,
  output logic                             axis_i_tready,
  input  logic                             axis_i_tvalid,
  input  logic                             axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]            axis_i_tkeep,
  input  logic [AXIS_BYTES*8-1:0]          axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]        axis_i_tuser,
  input  logic [HEADER_LENGTH_BYTES*8-1:0] axis_i_header,
  input  logic                             axis_o_tready,
  output logic                             axis_o_tvalid,
  output logic                             axis_o_tlast,
  output logic [AXIS_BYTES-1:0]            axis_o_tkeep,
  output logic [AXIS_BYTES*8-1:0]          axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0]        axis_o_tuser,
  output logic [HEADER_LENGTH_BYTES*8-1:0] axis_o_header,
  output logic [STAT_CTR_WIDTH-1:0]        stat_passed,
  output logic [STAT_CTR_WIDTH-1:0]        stat_dropped,
  output state_t                           dbg_state
);

  state_t state;
  state_t state_nxt;
  logic   hit;
  logic   pass_beat;
  logic   slice_free;
  logic   accept;

  // The compare only matters on a FIRST beat; later beats follow the latched state,
  // so configuration changes mid-packet have no effect.
  assign hit = header_match(HDR_MAX_BITS'(axis_i_header), HDR_MAX_BITS'(cfg_match),
                            HDR_MAX_BITS'(cfg_mask), cfg_invert);

  // Per-beat pass/drop decision.
  always_comb begin
    pass_beat = 1'b0;
    case (state)
      FIRST:   pass_beat = hit;
      PASS:    pass_beat = 1'b1;
      default: pass_beat = 1'b0;
    endcase
  end

  // Passed beats wait for room in the slice; dropped beats are always swallowed.
  assign slice_free    = !axis_o_tvalid || axis_o_tready;
  assign axis_i_tready = aresetn && (pass_beat ? slice_free : 1'b1);
  assign accept        = axis_i_tvalid && axis_i_tready;
  assign dbg_state     = state;

  // Next-state logic: only accepted beats move the packet FSM.
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        FIRST: begin
          if (!axis_i_tlast) begin
            state_nxt = hit ? PASS : DROP;
          end
        end
        PASS, DROP: begin
          if (axis_i_tlast) begin
            state_nxt = FIRST;
          end
        end
        default: state_nxt = FIRST;
      endcase
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= FIRST;
    end else begin
      state <= state_nxt;
    end
  end

  // Output register slice: load on a passed beat, drain on downstream ready, hold otherwise.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      axis_o_tvalid <= 1'b0;
      axis_o_tlast  <= 1'b0;
      axis_o_tkeep  <= '0;
      axis_o_tdata  <= '0;
      axis_o_tuser  <= '0;
      axis_o_header <= '0;
    end else if (accept && pass_beat) begin
      axis_o_tvalid <= 1'b1;
      axis_o_tlast  <= axis_i_tlast;
      axis_o_tkeep  <= axis_i_tkeep;
      axis_o_tdata  <= axis_i_tdata;
      axis_o_tuser  <= axis_i_tuser;
      axis_o_header <= axis_i_header;
    end else if (axis_o_tready) begin
      axis_o_tvalid <= 1'b0;
    end
  end

  axis_filter_stats #(
    .STAT_CTR_WIDTH(STAT_CTR_WIDTH)
  ) u_stats (
    .clk          (clk),
    .aresetn      (aresetn),
    .inc_pass     (accept && axis_i_tlast && pass_beat),
    .inc_drop     (accept && axis_i_tlast && !pass_beat),
    .stat_passed  (stat_passed),
    .stat_dropped (stat_dropped)
  );

endmodule

// File: doc/axis_header_filter.md
Name: axis_header_filter

Overview:
- Sits directly downstream of the header-tagging stage on the receive path.
- Consumes a packed AXI stream with its stripped header carried on a sideband bus.
- On the first beat of each packet, compares the header against a runtime match/mask.
- Forwards the whole packet, with its header, or silently drops it; counts passed and dropped packets.

Parameters:
- AXIS_BYTES, 1, stream data width in bytes.
- AXIS_USER_BITS, 1, tuser width.
- HEADER_LENGTH_BYTES, 1, sideband header width in bytes (≥1).
- STAT_CTR_WIDTH, 32, width of the packet statistics counters.

Ports:
- clk  input  1  clock.
- aresetn  input  1  asynchronous active-low reset.
- cfg_match  input  HEADER_LENGTH_BYTES*8  header value to match.
- cfg_mask  input  HEADER_LENGTH_BYTES*8  1 = bit participates in the compare.
- cfg_invert  input  1  1 = drop on match instead of pass on match.
- axis_i_tready  output  1  input ready.
- axis_i_tvalid  input  1  input valid.
- axis_i_tlast  input  1  input last.
- axis_i_tkeep  input  AXIS_BYTES  input keep.
- axis_i_tdata  input  AXIS_BYTES*8  input data.
- axis_i_tuser  input  AXIS_USER_BITS  input user.
- axis_i_header  input  HEADER_LENGTH_BYTES*8  header; valid with every beat and stable for the whole packet.
- axis_o_tready  input  1  output ready.
- axis_o_tvalid  output  1  output valid.
- axis_o_tlast  output  1  output last.
- axis_o_tkeep  output  AXIS_BYTES  output keep.
- axis_o_tdata  output  AXIS_BYTES*8  output data.
- axis_o_tuser  output  AXIS_USER_BITS  output user.
- axis_o_header  output  HEADER_LENGTH_BYTES*8  header registered alongside each output beat.
- stat_passed  output  STAT_CTR_WIDTH  count of forwarded packets, saturating.
- stat_dropped  output  STAT_CTR_WIDTH  count of dropped packets, saturating.

Behaviour:
- Reset (async assert, sync release):
  - state=FIRST.
  - axis_o_tvalid=0; all axis_o_* data/sideband = 0.
  - stat_passed = stat_dropped = 0.
  - axis_i_tready=0 while aresetn is low.
- Match function: hit = (((axis_i_header ^ cfg_match) & cfg_mask) == 0) ^ cfg_invert.
  - Evaluated only on the FIRST-state beat.
  - cfg_* are sampled only then; changes mid-packet have no effect.
  - cfg_mask = 0 with cfg_invert = 0 passes everything.
- States:
  - FIRST: awaiting the first beat of a packet.
  - PASS: forwarding the packet.
  - DROP: discarding the packet.
- Transitions, on an accepted beat (axis_i_tvalid && axis_i_tready) only:
  - FIRST→PASS if hit && !tlast.
  - FIRST→DROP if !hit && !tlast.
  - FIRST stays FIRST if tlast (single-beat packet; the decision applies to that beat).
  - PASS/DROP→FIRST on tlast.
- Per-beat decision: the FIRST beat uses hit; later beats use the latched state.
- Output stage: one register slice.
  - axis_i_tready = !axis_o_tvalid || axis_o_tready when the beat is passed.
  - axis_i_tready = 1 when the beat is dropped.
  - Latency 1 cycle; full throughput, one beat per cycle with sustained ready.
- Dropped beats never assert axis_o_tvalid and never stall on axis_o_tready.
- Registered output fields hold while axis_o_tvalid && !axis_o_tready.
- Statistics:
  - On an accepted tlast beat, increment stat_passed (decision pass) or stat_dropped (decision drop).
  - Both counters saturate at all-ones, no wrap.
- Empty beats with tkeep=0 are forwarded or dropped like any other beat; no repacking is done.
- Reset mid-packet: state returns to FIRST and the in-flight output beat is lost. The next input beat is treated as a packet start. Upstream is reset together with this block.

Decomposition:
- Shared package axis_filter_pkg holds:
  - the state enum (FIRST, PASS, DROP);
  - the pure function header_match(header, match, mask, invert) returning hit.
- One natural sub-module: axis_filter_stats, two saturating STAT_CTR_WIDTH counters with inc_pass/inc_drop strobes.
- The register slice is inline, because the existing register stage uses synchronous reset.

Test Plan (AXIS_BYTES=2, HEADER_LENGTH_BYTES=3, STAT_CTR_WIDTH=4):
- Match pass:
  - Stimulus: cfg_match=0xABCDEF, mask=0xFFFFFF; packet header=0xABCDEF, 3 beats 0x0001/0x0002/0x0003 with tlast on beat 3, o_tready=1.
  - Required: same 3 beats out 1 cycle later, axis_o_header=0xABCDEF on each; stat_passed=1.
- Mismatch drop:
  - Stimulus: header=0xABCD00, same config, 4 beats.
  - Required: i_tready=1 every cycle, o_tvalid never asserts; stat_dropped=1.
- Masked/inverted:
  - Stimulus: mask=0xFF0000, invert=1, header=0xAB1234.
  - Required: packet dropped. The same header with invert=0 is passed.
- Single-beat packets:
  - Stimulus: back-to-back one-beat packets with headers alternating match/mismatch, 6 packets.
  - Required: exactly beats 1, 3, 5 emitted; stat_passed=3, stat_dropped=3; no bubbles on the input.
- Backpressure:
  - Stimulus: passed 5-beat packet with o_tready toggling 1,0,0,1,...
  - Required: no beat lost or duplicated; outputs stable while stalled. cfg_match changed mid-packet does not alter forwarding.
- Saturation/reset:
  - Stimulus: 17 dropped packets, then aresetn pulsed low mid-packet.
  - Required: stat_dropped=15 before reset; all outputs and counters return to 0 immediately.
